// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and the conditional-negate helper used around the datapath.
package mult_div_pkg;

    localparam int MAX_WIDTH = 64;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } stateT;

    // Wide enough for a full 2*MAX_WIDTH product; callers size-cast the result.
    typedef logic [2*MAX_WIDTH-1:0] wideT;

    function automatic wideT condNeg(input wideT v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result
// registers. One 2W+1-bit accumulator serves both algorithms on magnitudes.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    mult_div_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2 * WIDTH + 1;

    stateT            state;
    logic             busyReg;
    logic             doneReg;
    logic             divZeroReg;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;

    logic             isDiv;
    logic             zeroCase;
    logic             negLo;
    logic             negHi;
    logic [WIDTH-1:0] opnd;
    logic [AW-1:0]    acc;
    logic [CW-1:0]    count;

    logic             signedIn;
    logic             signA;
    logic             signB;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    logic [AW-1:0]    accNext;
    logic [AW-1:0]    shifted;
    logic [WIDTH:0]   upper;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    // Operand magnitudes; unsigned ops never look at the sign bits.
    always_comb begin
        signedIn = ~bus.op[0];
        signA    = signedIn & bus.a[WIDTH-1];
        signB    = signedIn & bus.b[WIDTH-1];
        magA     = WIDTH'(condNeg(wideT'(bus.a), signA));
        magB     = WIDTH'(condNeg(wideT'(bus.b), signB));
    end

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps the dividend in the low half and shifts left.
    always_comb begin
        shifted = {acc[AW-2:0], 1'b0};
        upper   = shifted[AW-1:WIDTH];
        diff    = upper - {1'b0, opnd};
        sum     = acc[AW-1:WIDTH] + {1'b0, (acc[0] ? opnd : '0)};
        if (isDiv) begin
            if (upper >= {1'b0, opnd}) begin
                accNext = {diff, shifted[WIDTH-1:1], 1'b1};
            end else begin
                accNext = shifted;
            end
        end else begin
            accNext = {1'b0, sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = (2*WIDTH)'(condNeg(wideT'(acc[2*WIDTH-1:0]), negLo));
        if (isDiv) begin
            resHi = WIDTH'(condNeg(wideT'(acc[2*WIDTH-1:WIDTH]), negHi));
            resLo = WIDTH'(condNeg(wideT'(acc[WIDTH-1:0]), negLo));
        end else begin
            resHi = prod[2*WIDTH-1:WIDTH];
            resLo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
            divZeroReg <= 1'b0;
            hiReg      <= '0;
            loReg      <= '0;
            isDiv      <= 1'b0;
            zeroCase   <= 1'b0;
            negLo      <= 1'b0;
            negHi      <= 1'b0;
            opnd       <= '0;
            acc        <= '0;
            count      <= '0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        isDiv      <= bus.op[1];
                        negLo      <= signA ^ signB;
                        negHi      <= signA;
                        acc        <= {{(WIDTH+1){1'b0}}, (bus.op[1] ? magA : magB)};
                        opnd       <= bus.op[1] ? magB : magA;
                        zeroCase   <= bus.op[1] && (bus.b == '0);
                        // A zero divisor still spends one RUN edge so its done
                        // lands two edges after accept.
                        count      <= (bus.op[1] && (bus.b == '0)) ? '0 : CW'(WIDTH - 1);
                        divZeroReg <= 1'b0;
                        busyReg    <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    acc <= accNext;
                    if (count == '0) begin
                        state <= FINISH;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                FINISH: begin
                    if (zeroCase) begin
                        divZeroReg <= 1'b1;
                    end else begin
                        hiReg <= resHi;
                        loReg <= resLo;
                    end
                    doneReg <= 1'b1;
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busyReg;
    assign bus.done     = doneReg;
    assign bus.div_zero = divZeroReg;
    assign bus.hi       = hiReg;
    assign bus.lo       = loReg;

endmodule
